// File: rtl/cwc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cwc_capture_pkg
// Purpose  : Shared types and constants for the ChipWatcher capture sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cwc_capture_pkg;

    // Capture sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4,
        READ      = 3'd5
    } cwc_state_t;

    // Read latency of the capture RAM in clock cycles (address to data)
    localparam int c_RD_LATENCY = 1;

    // Address width needed to index a RAM of the given depth
    function automatic int cwc_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cwc_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : cwc_rd_skid
// Purpose  : Two-entry valid/ready output buffer for the capture readout path.
//            Holds RAM read data that arrives one cycle after the address so
//            that downstream backpressure never drops or repeats a sample.
// Revision : 1.0 - initial release
// ============================================================================
module cwc_rd_skid
    import cwc_capture_pkg::*;
#(
    parameter int DATA_W = 132
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] r_data [2];
    logic [1:0]        r_last;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop     = (r_count != 2'd0) && out_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_data[r_rd_ptr];
    assign out_last  = r_last[r_rd_ptr];
    assign count     = r_count;

    // Ping-pong storage: write side fills one slot while the read side presents the other
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
            end
            r_last   <= 2'b00;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (in_valid) begin
                r_data[r_wr_ptr] <= in_data;
                r_last[r_wr_ptr] <= in_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({in_valid, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cwc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cwc_capture_ctrl
// Purpose  : ChipWatcher capture sequencer. Arms the sample RAM, fills a
//            circular window around a trigger with a programmable pre/post
//            split, then streams the window out oldest-first.
// Options  : CWC_CAPTURE_QUAL_EN - adds qual_in; only qualified cycles are
//            written, counted and eligible as trigger.
// Revision : 1.0 - initial release
// ============================================================================
module cwc_capture_ctrl
    import cwc_capture_pkg::*;
#(
    parameter int DATA_W = 132,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = cwc_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] post_len,
    input  logic [DATA_W-1:0] probe_din,
    input  logic              trig_in,
`ifdef CWC_CAPTURE_QUAL_EN
    input  logic              qual_in,
`endif
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              rd_start,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam logic [ADDR_W-1:0] c_MAX_ADDR    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_DEPTH_CNT   = (ADDR_W + 1)'(DEPTH);
    // Reads that may be outstanding beyond skid occupancy without overflow
    localparam logic [2:0]        c_SKID_CREDIT = 3'(2 - c_RD_LATENCY);

    cwc_state_t        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_post_len;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_triggered;
    logic [ADDR_W:0]   r_rd_left;
    logic              r_pend;
    logic              r_pend_last;

    logic              w_qual;
    logic              w_write;
    logic              w_trig;
    logic              w_arm;
    logic              w_rd_start;
    logic [ADDR_W-1:0] w_pre;
    logic [ADDR_W-1:0] w_oldest;
    logic [1:0]        w_skid_count;
    logic [2:0]        w_occ;
    logic              w_pop;
    logic              w_issue;

`ifdef CWC_CAPTURE_QUAL_EN
    assign w_qual = qual_in;
`else
    assign w_qual = 1'b1;
`endif

    // Capture-side decode; abort suppresses any write or trigger in its cycle
    assign w_write    = !abort && w_qual &&
                        ((r_state == PRE_FILL) || (r_state == WAIT_TRIG) || (r_state == POST));
    assign w_trig     = !abort && w_qual && trig_in && (r_state == WAIT_TRIG);
    assign w_arm      = arm && !abort && ((r_state == IDLE) || (r_state == DONE));
    assign w_rd_start = rd_start && !abort && !arm && (r_state == DONE);
    assign w_pre      = c_MAX_ADDR - post_len;
    assign w_oldest   = r_trig_addr + r_post_len + ADDR_W'(1);

    // Readout issue: only request a RAM word when the skid is guaranteed room for it
    assign w_pop   = rd_valid && rd_ready;
    assign w_occ   = {1'b0, w_skid_count} + {2'b00, r_pend};
    assign w_issue = (r_state == READ) && !abort && (r_rd_left != '0) &&
                     ((w_occ - {2'b00, w_pop}) <= c_SKID_CREDIT);

    // Sequencer, registered write port and read address generation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_post_len  <= '0;
            r_trig_addr <= '0;
            r_raddr     <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_triggered <= 1'b0;
            r_rd_left   <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_waddr <= r_wptr;
                r_wdata <= probe_din;
                r_wptr  <= r_wptr + ADDR_W'(1);
            end

            r_pend      <= w_issue;
            r_pend_last <= w_issue && (r_rd_left == (ADDR_W + 1)'(1));
            if (w_issue) begin
                r_raddr   <= r_raddr + ADDR_W'(1);
                r_rd_left <= r_rd_left - (ADDR_W + 1)'(1);
            end

            if (abort) begin
                r_state <= IDLE;
                r_pend  <= 1'b0;
            end else if (w_arm) begin
                r_wptr      <= '0;
                r_triggered <= 1'b0;
                r_post_len  <= post_len;
                r_cnt       <= w_pre;
                r_state     <= (w_pre == '0) ? WAIT_TRIG : PRE_FILL;
            end else begin
                case (r_state)
                    PRE_FILL: begin
                        if (w_write) begin
                            r_cnt <= r_cnt - ADDR_W'(1);
                            if (r_cnt == ADDR_W'(1)) begin
                                r_state <= WAIT_TRIG;
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (w_trig) begin
                            r_trig_addr <= r_wptr;
                            r_triggered <= 1'b1;
                            r_cnt       <= r_post_len;
                            r_state     <= (r_post_len == '0) ? DONE : POST;
                        end
                    end
                    POST: begin
                        if (w_write) begin
                            r_cnt <= r_cnt - ADDR_W'(1);
                            if (r_cnt == ADDR_W'(1)) begin
                                r_state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (w_rd_start) begin
                            r_raddr   <= w_oldest;
                            r_rd_left <= c_DEPTH_CNT;
                            r_state   <= READ;
                        end
                    end
                    READ: begin
                        if (w_pop && rd_last) begin
                            r_state <= DONE;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    cwc_rd_skid #(
        .DATA_W (DATA_W)
    ) u_rd_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (r_pend),
        .in_data   (ram_rdata),
        .in_last   (r_pend_last),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .out_data  (rd_data),
        .out_last  (rd_last),
        .count     (w_skid_count)
    );

    assign ram_we    = r_we;
    assign ram_waddr = r_waddr;
    assign ram_wdata = r_wdata;
    assign ram_raddr = r_raddr;
    assign busy      = (r_state == PRE_FILL) || (r_state == WAIT_TRIG) || (r_state == POST);
    assign done      = (r_state == DONE);
    assign triggered = r_triggered;
    assign trig_addr = r_trig_addr;

endmodule
`default_nettype wire

// File: tb/tb_cwc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cwc_capture_ctrl
// Purpose  : Self-checking bench for cwc_capture_ctrl (DEPTH=16). Expected RAM
//            writes and readout beats are queued as stimulus is driven and
//            consumed as the design produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cwc_capture_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] post_len;
    logic [DATA_W-1:0] probe_din;
    logic              trig_in;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_start;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic              triggered;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
`ifdef CWC_CAPTURE_QUAL_EN
    logic              qual_in = 1'b1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cap_id = 0;

    logic [ADDR_W+DATA_W-1:0] wq [$];
    logic [DATA_W-1:0]        rq [$];
    logic [DATA_W-1:0]        win [DEPTH];
    logic [ADDR_W-1:0]        exp_trig;
    logic [ADDR_W+DATA_W-1:0] w_exp;
    logic [DATA_W-1:0]        mem [DEPTH];

    always #5 clk = ~clk;

    cwc_capture_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .post_len  (post_len),
        .probe_din (probe_din),
        .trig_in   (trig_in),
`ifdef CWC_CAPTURE_QUAL_EN
        .qual_in   (qual_in),
`endif
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .rd_start  (rd_start),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .triggered (triggered),
        .done      (done),
        .trig_addr (trig_addr)
    );

    // Capture RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: RAM writes and readout beats, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    check_eq("unexpected_write", ram_we, 0);
                end else begin
                    w_exp = wq.pop_front();
                    check_eq("waddr", ram_waddr, w_exp[ADDR_W+DATA_W-1:DATA_W]);
                    check_eq("wdata", ram_wdata, w_exp[DATA_W-1:0]);
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    check_eq("unexpected_rd_valid", rd_valid, 0);
                end else begin
                    check_eq("rd_data", rd_data, rq[0]);
                    if (rd_ready) begin
                        check_eq("rd_last", rd_last, (rq.size() == 1));
                        void'(rq.pop_front());
                    end
                end
            end
        end
    end

    // Arm and feed one capture; the trigger is accepted at the first WAIT_TRIG
    // sample at or after trig_k. abort_at>0 aborts on that sample instead.
    task automatic run_capture(input int post, input int trig_k, input bit hold, input int abort_at);
        int pre;
        int kt;
        int total;
        pre   = DEPTH - 1 - post;
        kt    = (trig_k > pre) ? trig_k : pre + 1;
        total = kt + post;
        cap_id++;
        post_len  = ADDR_W'(post);
        arm       = 1'b1;
        trig_in   = hold;
        probe_din = 32'hDEAD0000 + 32'(cap_id);
        tick();
        arm = 1'b0;
        for (int k = 1; k <= total; k++) begin
            probe_din = {8'hC0, 8'(cap_id), 16'(k)};
            trig_in   = hold || (k == trig_k);
            if (k == abort_at) begin
                abort = 1'b1;
                tick();
                abort   = 1'b0;
                trig_in = 1'b0;
                return;
            end
            wq.push_back({ADDR_W'((k - 1) % DEPTH), probe_din});
            if (k > total - DEPTH) win[k - (total - DEPTH) - 1] = probe_din;
            tick();
            if (k == 1) check_eq("busy_running", busy, 1);
        end
        trig_in  = 1'b0;
        exp_trig = ADDR_W'((kt - 1) % DEPTH);
        check_eq("done_after_window", done, 1);
        check_eq("triggered", triggered, 1);
        check_eq("trig_addr", trig_addr, exp_trig);
        check_eq("busy_done", busy, 0);
    endtask

    function automatic logic ready_pat(input int mode, input int i);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (i % 4 == 0) || (i % 4 == 3);
        return 1'b0;
    endfunction

    // Stream the captured window and check it drains in order
    task automatic readout(input int mode);
        int i;
        for (int j = 0; j < DEPTH; j++) rq.push_back(win[j]);
        rd_start = 1'b1;
        rd_ready = ready_pat(mode, 0);
        tick();
        rd_start = 1'b0;
        i = 1;
        while (rq.size() != 0 && i < 400) begin
            rd_ready = ready_pat(mode, i);
            tick();
            i++;
        end
        check_eq("readout_drained", rq.size(), 0);
        check_eq("write_queue_empty", wq.size(), 0);
        check_eq("done_after_read", done, 1);
        rd_ready = 1'b0;
        tick();
        check_eq("rd_valid_idle", rd_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ram_we"},    ram_we, 0);
        check_eq({tag, "_ram_waddr"}, ram_waddr, 0);
        check_eq({tag, "_ram_wdata"}, ram_wdata, 0);
        check_eq({tag, "_ram_raddr"}, ram_raddr, 0);
        check_eq({tag, "_rd_valid"},  rd_valid, 0);
        check_eq({tag, "_rd_data"},   rd_data, 0);
        check_eq({tag, "_rd_last"},   rd_last, 0);
        check_eq({tag, "_busy"},      busy, 0);
        check_eq({tag, "_triggered"}, triggered, 0);
        check_eq({tag, "_done"},      done, 0);
        check_eq({tag, "_trig_addr"}, trig_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; post_len = '0; probe_din = '0;
        trig_in = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // post_len=4, trigger on 20th cycle after arm: trig_addr 3, oldest 8
        run_capture(4, 20, 1'b0, 0);
        readout(0);

        // post_len=0, trigger held from arm: accepted at addr 15; stalled readout
        run_capture(0, 0, 1'b1, 0);
        readout(1);

        // post_len=DEPTH-1: no pre-fill, straight to WAIT_TRIG
        run_capture(15, 1, 1'b0, 0);
        readout(1);

        // abort after 2 of 4 post-trigger writes
        run_capture(4, 12, 1'b0, 15);
        check_eq("abort_ram_we", ram_we, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (4) tick();
        check_eq("abort_rd_ignored", rd_valid, 0);
        check_eq("abort_still_idle", done, 0);
        rd_ready = 1'b0;

        // arm and abort together from IDLE
        arm = 1'b1; abort = 1'b1; post_len = 4'd3;
        tick();
        arm = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check_eq("arm_abort_busy", busy, 0);
        check_eq("arm_abort_we", ram_we, 0);

        // reset during a stalled readout, then a full capture
        run_capture(4, 20, 1'b0, 0);
        for (int j = 0; j < DEPTH; j++) rq.push_back(win[j]);
        rd_start = 1'b1;
        rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        repeat (4) tick();
        check_eq("stalled_rd_valid", rd_valid, 1);
        rst = 1'b1;
        tick();
        check_all_zero("mid_read_rst");
        rq.delete();
        rst = 1'b0;
        tick();
        run_capture(2, 18, 1'b0, 0);
        readout(1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cwc_capture_ctrl.md
Name: cwc_capture_ctrl

Overview:
Capture sequencer for the ChipWatcher sample RAM. It arms the probe buffer and fills it as a circular window around a trigger event, with a programmable pre/post-trigger split. It then streams the captured window out oldest-first over a valid/ready port. It sits between the trigger-compare logic (trig_in) and the capture RAM, replacing free-running writes with a sequenced arm/trigger/readout cycle.

Parameters:
DATA_W, 132, probe sample width (concatenated probe bus)
DEPTH, 4096, capture RAM depth in samples; power of two, >= 4
ADDR_W, $clog2(DEPTH), RAM address width (derived, not overridden)

Ports:
clk  in  1  capture clock
rst  in  1  synchronous active-high reset
arm  in  1  pulse: start a new capture (accepted in IDLE/DONE only)
abort  in  1  pulse: cancel capture/readout, return to IDLE
post_len  in  ADDR_W  post-trigger sample count, 0..DEPTH-1; sampled on accepted arm
probe_din  in  DATA_W  probe sample for current cycle
trig_in  in  1  trigger condition, cycle-aligned with probe_din
ram_we  out  1  RAM write enable
ram_waddr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
ram_raddr  out  ADDR_W  RAM read address (RAM read latency fixed at 1 cycle)
ram_rdata  in  DATA_W  RAM read data
rd_start  in  1  pulse: begin readout (accepted in DONE only)
rd_valid  out  1  readout sample valid
rd_ready  in  1  downstream ready
rd_data  out  DATA_W  readout sample, oldest first
rd_last  out  1  marks sample DEPTH-1 of readout
busy  out  1  state is PRE_FILL, WAIT_TRIG or POST
triggered  out  1  trigger accepted for the current capture
done  out  1  state is DONE
trig_addr  out  ADDR_W  RAM address holding the trigger sample

Behaviour:
- Reset: state IDLE; all outputs 0; waddr counter 0.
- Write path registered: a sample presented in cycle N appears on ram_we/ram_waddr/ram_wdata in cycle N+1. ram_waddr increments modulo DEPTH after each write.
- PRE = DEPTH-1-post_len, latched on arm.
- IDLE: no writes. An arm moves to PRE_FILL, or to WAIT_TRIG if PRE==0. On arm: waddr<=0, triggered<=0.
- PRE_FILL: writes every cycle; trig_in ignored. Moves to WAIT_TRIG after PRE writes.
- WAIT_TRIG: writes every cycle; waddr wraps freely.
  - On trig_in=1, that sample is written, trig_addr latches its address, and triggered<=1.
  - Next state is POST, or DONE if post_len==0.
- POST: writes exactly post_len samples, then DONE. The total window is PRE+1+post_len = DEPTH, and the oldest sample sits at (trig_addr+post_len+1) mod DEPTH.
- DONE: no writes. Repeated rd_start or re-arm is allowed.
- READ (entered from DONE on rd_start):
  - ram_raddr starts at the oldest address and advances modulo DEPTH only when the output stage can accept data.
  - Exactly DEPTH samples are emitted; rd_last is asserted on the final one.
  - rd_data/rd_last hold stable while rd_valid=1 and rd_ready=0. No sample is dropped or duplicated.
  - The state returns to DONE on the final handshake.
- abort: from any state, next state is IDLE. ram_we and rd_valid are 0 from the next cycle; trig_addr is retained.
- Simultaneous events:
  - abort wins over arm and rd_start.
  - arm outside IDLE/DONE is ignored.
  - rd_start outside DONE is ignored.
  - arm in DONE starts a fresh capture.
- rst mid-capture or mid-readout returns to the reset state on the next edge.

Optional Feature:
CWC_CAPTURE_QUAL_EN adds input port qual_in (1 bit, aligned with probe_din).
- With the macro: writes occur only in cycles with qual_in=1. PRE/POST counters advance only on qualified writes, and a trigger is accepted only when qual_in=1.
- Without it: the port is absent and every cycle is qualified.

Decomposition:
- Package cwc_capture_pkg holds:
  - the state enum (IDLE, PRE_FILL, WAIT_TRIG, POST, DONE, READ; 3 bits);
  - a DEPTH-to-ADDR_W helper;
  - the RAM read latency constant (1).
- One sub-module, cwc_rd_skid: a 2-entry valid/ready output buffer that absorbs the 1-cycle RAM latency under backpressure.

Test Plan:
- DEPTH=16, post_len=4, arm, trig_in at 20th cycle after arm -> 11 pre samples then trigger write. trig_addr = 19 mod 16 = 3, DONE after 4 more writes, readout starts at addr 8, rd_last on 16th beat, trigger sample is beat 12.
- DEPTH=16, post_len=0, trig_in held high from arm -> trigger ignored during PRE_FILL. Accepted at first WAIT_TRIG cycle, trig_addr=15, DONE the next cycle.
- Readout with rd_ready toggled 1,0,0,1 repeating -> 16 beats in sequence, no gaps in data order, rd_data stable while stalled.
- abort in POST after 2 of 4 post writes -> IDLE next cycle, ram_we=0, busy=0, done=0. A subsequent rd_start is ignored.
- arm and abort in the same cycle from IDLE -> remains IDLE, no writes.
- rst asserted mid-READ with rd_ready=0 -> all outputs 0 next cycle. A following arm runs a full capture correctly.
